// File: rtl/ysyx_lsu_axi_bridge.sv
// ysyx_lsu_axi_bridge: LSU load/store requests to AXI4-Lite master with byte-lane alignment.
// Optional YSYX_LSU_BRIDGE_ALIGN_CHECK_EN rejects misaligned half/word accesses without bus traffic.
module ysyx_lsu_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [7:0]        lsu_rstrb,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  output logic              lsu_err,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready
);
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;
  state_t state, next;
  logic wr, err, aw_done, w_done, ld_bad, st_bad;
  logic [3:0] size;
  logic unused;
  assign unused = ^{lsu_wvalid, lsu_rstrb[7:4], lsu_wstrb[7:4]};
`ifdef YSYX_LSU_BRIDGE_ALIGN_CHECK_EN
  assign ld_bad = (lsu_rstrb == 8'h3 && lsu_araddr[0]) || (lsu_rstrb == 8'hf && lsu_araddr[1:0] != 2'b0);
  assign st_bad = (lsu_wstrb == 8'h3 && lsu_awaddr[0]) || (lsu_wstrb == 8'hf && lsu_awaddr[1:0] != 2'b0);
`else
  assign ld_bad = 1'b0;
  assign st_bad = 1'b0;
`endif
  assign m_arvalid  = state == RADDR;
  assign m_rready   = state == RDATA;
  assign m_awvalid  = state == WREQ && !aw_done;
  assign m_wvalid   = state == WREQ && !w_done;
  assign m_bready   = state == WRESP;
  assign lsu_rvalid = state == DONE && !wr;
  assign lsu_wready = state == DONE && wr;
  assign lsu_err    = state == DONE && err;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = lsu_arvalid ? (ld_bad ? DONE : RADDR) : lsu_awvalid ? (st_bad ? DONE : WREQ) : IDLE;
      RADDR:   next = m_arready ? RDATA : RADDR;
      RDATA:   next = m_rvalid ? DONE : RDATA;
      WREQ:    next = ((aw_done || m_awready) && (w_done || m_wready)) ? WRESP : WREQ;
      WRESP:   next = m_bvalid ? DONE : WRESP;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      m_araddr  <= '0;
      m_awaddr  <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      lsu_rdata <= '0;
      size      <= '0;
      wr        <= 1'b0;
      err       <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && lsu_arvalid) begin
        m_araddr <= lsu_araddr;
        size     <= lsu_rstrb[3:0];
        wr       <= 1'b0;
        err      <= ld_bad;
        if (ld_bad) lsu_rdata <= '0;
      end else if (state == IDLE && lsu_awvalid) begin
        m_awaddr <= lsu_awaddr;
        m_wdata  <= lsu_wdata << {lsu_awaddr[1:0], 3'b000};
        m_wstrb  <= lsu_wstrb[3:0] << lsu_awaddr[1:0];
        wr       <= 1'b1;
        err      <= st_bad;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end
      if (state == WREQ) begin
        aw_done <= aw_done || m_awready;
        w_done  <= w_done || m_wready;
      end
      if (state == RDATA && m_rvalid) begin
        lsu_rdata <= (m_rdata >> {m_araddr[1:0], 3'b000}) & {{8{size[3]}}, {8{size[2]}}, {8{size[1]}}, {8{size[0]}}};
        err       <= m_rresp != 2'b00;
      end
      if (state == WRESP && m_bvalid) err <= m_bresp != 2'b00;
    end
  end
endmodule

// File: tb/tb_ysyx_lsu_axi_bridge.sv
// tb_ysyx_lsu_axi_bridge: randomized bench with a negedge AXI slave model and lane-level reference model.
module tb_ysyx_lsu_axi_bridge;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] lsu_araddr, lsu_awaddr, lsu_wdata, lsu_rdata;
  logic [7:0] lsu_rstrb, lsu_wstrb;
  logic lsu_arvalid, lsu_awvalid, lsu_wvalid, lsu_rvalid, lsu_wready, lsu_err;
  logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
  logic [3:0] m_wstrb;
  logic [1:0] m_rresp, m_bresp;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  int errors = 0, checks = 0;
  logic [31:0] s_rdata;
  logic [1:0] s_rresp, s_bresp;
  int s_ardly, s_rdly, s_awdly, s_wdly, s_bdly;
  int rv_cnt = 0, wr_cnt = 0, ar_hs = 0, aw_hs = 0, w_hs = 0;
  logic [31:0] ar_addr, aw_addr, w_data;
  logic [3:0] w_strb;
  logic w_aw_low;
  logic r_pend, r_fire, b_pend, b_fire, aw_got, w_got;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;

  always #5 clk = ~clk;

  ysyx_lsu_axi_bridge dut (
    .clk(clk), .rst(rst),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_err(lsu_err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  // Slave decides its readies at negedge; a handshake is valid && new ready, taken at the next posedge.
  always @(negedge clk) begin
    if (lsu_rvalid) rv_cnt++;
    if (lsu_wready) wr_cnt++;
    if (rst) begin
      m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
      m_rdata = 0; m_rresp = 0; m_bresp = 0;
      r_pend = 0; r_fire = 0; b_pend = 0; b_fire = 0; aw_got = 0; w_got = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      if (r_fire) begin m_rvalid = 0; r_fire = 0; end
      if (r_pend) begin
        if (r_cnt >= s_rdly) begin m_rvalid = 1; m_rdata = s_rdata; m_rresp = s_rresp; end
        r_cnt++;
      end
      if (m_rvalid && m_rready) begin r_fire = 1; r_pend = 0; end
      m_arready = m_arvalid && ar_cnt >= s_ardly;
      if (m_arvalid) ar_cnt++;
      if (m_arvalid && m_arready) begin ar_hs++; ar_addr = m_araddr; ar_cnt = 0; r_pend = 1; r_cnt = 0; end
      if (b_fire) begin m_bvalid = 0; b_fire = 0; end
      if (b_pend) begin
        if (b_cnt >= s_bdly) begin m_bvalid = 1; m_bresp = s_bresp; end
        b_cnt++;
      end
      if (m_bvalid && m_bready) begin b_fire = 1; b_pend = 0; end
      m_awready = m_awvalid && aw_cnt >= s_awdly;
      if (m_awvalid) aw_cnt++;
      if (m_awvalid && m_awready) begin aw_hs++; aw_addr = m_awaddr; aw_cnt = 0; aw_got = 1; end
      m_wready = m_wvalid && w_cnt >= s_wdly;
      if (m_wvalid) w_cnt++;
      if (m_wvalid && m_wready) begin w_hs++; w_data = m_wdata; w_strb = m_wstrb; w_aw_low = !m_awvalid; w_cnt = 0; w_got = 1; end
      if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [7:0] sz);
    return sz == 8'h1 ? 1 : sz == 8'h3 ? 2 : 4;
  endfunction

  function automatic logic mis(input logic [31:0] a, input logic [7:0] sz);
`ifdef YSYX_LSU_BRIDGE_ALIGN_CHECK_EN
    return (nbytes(sz) == 2 && a[0]) || (nbytes(sz) == 4 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [7:0] sz, input logic [31:0] sd);
    int o = int'(a[1:0]);
    logic [31:0] r = '0;
    for (int j = 0; j < nbytes(sz); j++) if (o + j < 4) r[8*j +: 8] = sd[8*(o+j) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] a, input logic [31:0] wd);
    int o = int'(a[1:0]);
    logic [31:0] r = '0;
    for (int j = 0; j < 4; j++) if (j >= o) r[8*j +: 8] = wd[8*(j-o) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [31:0] a, input logic [7:0] sz);
    int o = int'(a[1:0]);
    logic [3:0] r = '0;
    for (int j = 0; j < 4; j++) r[j] = j >= o && (j - o) < nbytes(sz);
    return r;
  endfunction

  task automatic do_load(input logic [31:0] a, input logic [7:0] sz, input logic [31:0] sd,
                         input logic [1:0] rr, input int ard, input int rd);
    int rv0 = rv_cnt, wr0 = wr_cnt, ar0 = ar_hs, lat = 0;
    logic got = 0;
    logic bad = mis(a, sz);
    logic [31:0] er = bad ? 32'h0 : exp_load(a, sz, sd);
    logic ee = bad || rr != 2'b00;
    s_rdata = sd; s_rresp = rr; s_ardly = ard; s_rdly = rd;
    lsu_araddr = a; lsu_rstrb = sz; lsu_arvalid = 1;
    for (int i = 0; i < 40 && !got; i++) begin
      step;
      lat++;
      if (lsu_rvalid) begin
        got = 1;
        checks++;
        if (lsu_rdata !== er) begin errors++; $display("FAIL load_rdata a=%h sz=%h got %h want %h", a, sz, lsu_rdata, er); end
        checks++;
        if (lsu_err !== ee) begin errors++; $display("FAIL load_err a=%h got %b want %b", a, lsu_err, ee); end
      end
    end
    lsu_arvalid = 0;
    checks++;
    if (!got) begin errors++; $display("FAIL load_timeout a=%h no lsu_rvalid within 40 cycles", a); end
    if (got && ard == 0 && rd == 0) begin
      checks++;
      if (lat != (bad ? 1 : 3)) begin errors++; $display("FAIL load_latency a=%h got %0d want %0d", a, lat, bad ? 1 : 3); end
    end
    step;
    step;
    checks++;
    if (rv_cnt - rv0 != 1 || wr_cnt != wr0) begin errors++; $display("FAIL load_pulses rvalid=%0d wready=%0d want 1 0", rv_cnt - rv0, wr_cnt - wr0); end
    checks++;
    if (ar_hs - ar0 != (bad ? 0 : 1)) begin errors++; $display("FAIL load_ar_count got %0d want %0d", ar_hs - ar0, bad ? 0 : 1); end
    if (!bad) begin
      checks++;
      if (ar_addr !== a) begin errors++; $display("FAIL load_araddr got %h want %h", ar_addr, a); end
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [7:0] sz, input logic [31:0] wd,
                          input logic [1:0] br, input int awd, input int wdl, input int bd);
    int rv0 = rv_cnt, wr0 = wr_cnt, aw0 = aw_hs, w0 = w_hs, lat = 0;
    logic got = 0;
    logic bad = mis(a, sz);
    logic ee = bad || br != 2'b00;
    s_bresp = br; s_awdly = awd; s_wdly = wdl; s_bdly = bd;
    lsu_awaddr = a; lsu_wstrb = sz; lsu_wdata = wd; lsu_awvalid = 1; lsu_wvalid = 1;
    for (int i = 0; i < 40 && !got; i++) begin
      step;
      lat++;
      if (lsu_wready) begin
        got = 1;
        checks++;
        if (lsu_err !== ee) begin errors++; $display("FAIL store_err a=%h got %b want %b", a, lsu_err, ee); end
      end
    end
    lsu_awvalid = 0; lsu_wvalid = 0;
    checks++;
    if (!got) begin errors++; $display("FAIL store_timeout a=%h no lsu_wready within 40 cycles", a); end
    if (got && awd == 0 && wdl == 0 && bd == 0) begin
      checks++;
      if (lat != (bad ? 1 : 3)) begin errors++; $display("FAIL store_latency a=%h got %0d want %0d", a, lat, bad ? 1 : 3); end
    end
    step;
    step;
    checks++;
    if (wr_cnt - wr0 != 1 || rv_cnt != rv0) begin errors++; $display("FAIL store_pulses wready=%0d rvalid=%0d want 1 0", wr_cnt - wr0, rv_cnt - rv0); end
    checks++;
    if (aw_hs - aw0 != (bad ? 0 : 1) || w_hs - w0 != (bad ? 0 : 1)) begin
      errors++; $display("FAIL store_beats aw=%0d w=%0d want %0d each", aw_hs - aw0, w_hs - w0, bad ? 0 : 1);
    end
    if (!bad) begin
      checks++;
      if (aw_addr !== a || w_data !== exp_wdata(a, wd) || w_strb !== exp_wstrb(a, sz)) begin
        errors++;
        $display("FAIL store_beat got addr=%h data=%h strb=%b want addr=%h data=%h strb=%b",
                 aw_addr, w_data, w_strb, a, exp_wdata(a, wd), exp_wstrb(a, sz));
      end
    end
  endtask

  task automatic test_reset;
    rst = 1;
    lsu_araddr = 0; lsu_arvalid = 0; lsu_rstrb = 0; lsu_awaddr = 0; lsu_awvalid = 0;
    lsu_wdata = 0; lsu_wstrb = 0; lsu_wvalid = 0;
    s_rdata = 0; s_rresp = 0; s_bresp = 0; s_ardly = 0; s_rdly = 0; s_awdly = 0; s_wdly = 0; s_bdly = 0;
    step;
    step;
    checks++;
    if ({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, lsu_rvalid, lsu_wready, lsu_err} !== 8'h0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000000", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, lsu_rvalid, lsu_wready, lsu_err});
    end
    checks++;
    if (lsu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", lsu_rdata); end
    checks++;
    if ({m_araddr, m_awaddr, m_wdata, m_wstrb} !== 100'h0) begin
      errors++; $display("FAIL reset_bus got ar=%h aw=%h wd=%h ws=%b want 0", m_araddr, m_awaddr, m_wdata, m_wstrb);
    end
    rst = 0;
    step;
  endtask

  task automatic test_directed;
    do_load(32'h8000_0004, 8'hf, 32'hDEAD_BEEF, 2'b00, 0, 0);
    do_load(32'h8000_0003, 8'h1, 32'hAB00_0000, 2'b00, 0, 0);
    do_store(32'h8000_0002, 8'h3, 32'h0000_1234, 2'b00, 0, 0, 0);
    do_load(32'h8000_0002, 8'hf, 32'h1122_3344, 2'b00, 0, 0);
    do_store(32'h8000_0001, 8'h3, 32'hCAFE_F00D, 2'b00, 0, 0, 0);
  endtask

  task automatic test_split_ready;
    do_store(32'h8000_0010, 8'hf, 32'h5566_7788, 2'b00, 0, 2, 1);
    checks++;
    if (w_aw_low !== 1'b1) begin errors++; $display("FAIL aw_first awvalid at w handshake got %b want 0", !w_aw_low); end
    do_store(32'h8000_0020, 8'h1, 32'h0000_00EE, 2'b00, 3, 0, 0);
    checks++;
    if (w_aw_low !== 1'b0) begin errors++; $display("FAIL w_first awvalid at w handshake got %b want 1", !w_aw_low); end
  endtask

  task automatic test_back_to_back;
    int rv0 = rv_cnt, wr0 = wr_cnt, aw0 = aw_hs;
    logic got = 0;
    s_rdata = 32'h0BAD_F00D; s_rresp = 0; s_bresp = 0;
    s_ardly = 0; s_rdly = 0; s_awdly = 0; s_wdly = 0; s_bdly = 0;
    lsu_araddr = 32'h8000_0040; lsu_rstrb = 8'hf; lsu_arvalid = 1;
    lsu_awaddr = 32'h8000_0044; lsu_wstrb = 8'hf; lsu_wdata = 32'h1357_9BDF; lsu_awvalid = 1; lsu_wvalid = 1;
    for (int i = 0; i < 40 && !got; i++) begin
      step;
      if (lsu_rvalid) begin
        got = 1;
        checks++;
        if (lsu_wready !== 1'b0 || aw_hs != aw0) begin errors++; $display("FAIL both_order wready=%b aw=%0d want 0 0", lsu_wready, aw_hs - aw0); end
        checks++;
        if (lsu_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL both_rdata got %h want 0badf00d", lsu_rdata); end
      end
    end
    lsu_arvalid = 0;
    checks++;
    if (!got) begin errors++; $display("FAIL both_load_timeout no lsu_rvalid"); end
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step;
      if (lsu_wready) got = 1;
    end
    lsu_awvalid = 0; lsu_wvalid = 0;
    checks++;
    if (!got) begin errors++; $display("FAIL both_store_timeout no lsu_wready"); end
    step;
    step;
    checks++;
    if (rv_cnt - rv0 != 1 || wr_cnt - wr0 != 1 || aw_hs - aw0 != 1 || w_data !== 32'h1357_9BDF) begin
      errors++; $display("FAIL both_counts rvalid=%0d wready=%0d aw=%0d wdata=%h want 1 1 1 13579bdf", rv_cnt - rv0, wr_cnt - wr0, aw_hs - aw0, w_data);
    end
  endtask

  task automatic test_resp_err;
    do_load(32'h8000_0008, 8'hf, 32'h0101_0101, 2'b10, 0, 0);
    do_load(32'h8000_000c, 8'hf, 32'h0202_0202, 2'b00, 0, 0);
    do_store(32'h8000_000c, 8'h1, 32'h0000_0042, 2'b11, 0, 0, 2);
    do_store(32'h8000_000d, 8'h1, 32'h0000_0043, 2'b00, 0, 0, 0);
  endtask

  task automatic test_reset_mid;
    int rv0 = rv_cnt;
    logic got = 0;
    s_ardly = 0; s_rdly = 6; s_rdata = 32'hFFFF_FFFF; s_rresp = 0;
    lsu_araddr = 32'h8000_0080; lsu_rstrb = 8'hf; lsu_arvalid = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      step;
      if (m_rready) got = 1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rstmid_timeout never reached RDATA"); end
    rst = 1;
    lsu_arvalid = 0;
    step;
    checks++;
    if ({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, lsu_rvalid} !== 6'h0) begin
      errors++; $display("FAIL rstmid_valids got %b want 000000", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, lsu_rvalid});
    end
    rst = 0;
    for (int i = 0; i < 10; i++) step;
    checks++;
    if (rv_cnt != rv0 || m_rready !== 1'b0) begin errors++; $display("FAIL rstmid_pulse rvalid=%0d rready=%b want 0 0", rv_cnt - rv0, m_rready); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      int k = $urandom_range(0, 2);
      logic [7:0] sz = k == 0 ? 8'h1 : k == 1 ? 8'h3 : 8'hf;
      logic [31:0] a = 32'h8000_0000 | 32'($urandom_range(0, 255));
      logic z = $urandom_range(0, 1) == 1;
      logic [1:0] rsp = $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 1) == 1)
        do_load(a, sz, $urandom, rsp, z ? 0 : $urandom_range(0, 3), z ? 0 : $urandom_range(0, 3));
      else
        do_store(a, sz, $urandom, rsp, z ? 0 : $urandom_range(0, 3), z ? 0 : $urandom_range(0, 3), z ? 0 : $urandom_range(0, 3));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_directed;
    test_split_ready;
    test_back_to_back;
    test_resp_err;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
